uart_tx_buffer: RTL
===================

# uart_tx_buffer

Elastic byte buffer between `uci_handler` and `uart_transmit` on the FPGA-to-host path. It accepts characters from `uci_handler` over a valid/ready handshake and stores them in a FIFO. It then launches them one at a time into `uart_transmit` using that block's `trigger_in`/`busy_out` protocol. This lets `uci_handler` emit a whole `info`/`bestmove` line without stalling on the 115200-baud serial rate.

## Interface

**Parameters**
- `DEPTH`, default 64: FIFO capacity in bytes; must be a power of two, at least 4.
- `GUARD`, default 2: cycles after a trigger during which `busy_in` is ignored.

**Ports**
- `clk_in`  in  1  system clock (100 MHz).
- `rst_in`  in  1  reset; synchronous, active-high.
- `char_in`  in  8  byte from `uci_handler`.
- `char_in_valid`  in  1  `char_in` is valid this cycle.
- `char_in_ready`  out  1  buffer can accept a byte this cycle.
- `data_byte_out`  out  8  byte to `uart_transmit.data_byte_in`.
- `trigger_out`  out  1  one-cycle launch pulse to `uart_transmit.trigger_in`.
- `busy_in`  in  1  `uart_transmit.busy_out`.
- `level_out`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation

**Write side**
- A push occurs when `char_in_valid && char_in_ready`.
- `char_in_ready` is `level_out != DEPTH`. It is combinational from the count and does not depend on a same-cycle pop.
- Bytes are stored in order. Nothing is dropped while ready is honoured.

**Read side FSM**
- `IDLE`: if the FIFO is not empty and `busy_in` is low:
  - pop the head into the `data_byte_out` register;
  - assert `trigger_out` for exactly that next cycle;
  - go to `GUARD_WAIT`.
- `GUARD_WAIT`: count `GUARD` cycles, ignoring `busy_in` (covers transmitter busy-assert latency), then go to `DRAIN`.
- `DRAIN`: when `busy_in` is low, go to `IDLE`.

**Rules and boundary conditions**
- `data_byte_out` holds its value from launch until the next launch.
- Push and pop in the same cycle leave `level_out` unchanged. Pointers wrap modulo `DEPTH`.
- When full, `char_in_ready` stays low even if a pop happens that cycle; ready rises the following cycle.
- When empty, the FSM stays in `IDLE` and `trigger_out` stays low.
- `rst_in` mid-transfer:
  - the FIFO is flushed and the FSM returns to `IDLE` on the next edge;
  - the byte already launched is abandoned;
  - no trigger is issued until `busy_in` reads low.

**Reset values**
- `char_in_ready` = 1
- `data_byte_out` = 8'h00
- `trigger_out` = 0
- `level_out` = 0
- FSM = `IDLE`, pointers = 0

## Timing

- Minimum latency from an accepted push into an empty, idle buffer to `trigger_out` high: 2 cycles (cycle 0 write, cycle 1 pop, cycle 2 trigger).
- Back-to-back launches are spaced by at least 2 + `GUARD` cycles plus the `busy_in`-high time.
- `level_out` reflects pushes and pops one cycle after the accepting edge.
- `trigger_out` is never high for two consecutive cycles.
- `trigger_out` is never asserted while `busy_in` is high in `IDLE`.

## Configuration

Controlled by `UART_TX_BUF_CRLF_EN`.

- **Defined:**
  - when the FIFO head is 8'h0A, the FSM first launches 8'h0D without popping and sets a `pending_lf` flag;
  - the following launch pops and sends 8'h0A, clearing the flag;
  - `pending_lf` resets to 0;
  - each '\n' costs one extra serial frame.
- **Undefined:** bytes are sent verbatim, and `pending_lf` logic is absent.

## Structure

- Add `UART_TX_BUF_DEPTH_DEFAULT` and a `tx_buf_state_t` enum (`IDLE`, `GUARD_WAIT`, `DRAIN`) to the shared types package.
- Factor out one sub-module, `sync_fifo`: parameterised width and depth, push/pop/level/full/empty, synchronous reset. It is reusable on the receive path.
- The FSM and CRLF logic live in `uart_tx_buffer`.
- In `top_level`, instantiate it between `uci.char_out*` and `transmitter`.

## Test plan

1. **Single-byte launch:** after reset, push 8'h41 once with a `uart_transmit` model that has busy = 1 for 10 cycles starting 1 cycle after trigger → `trigger_out` pulses at cycle 2 with `data_byte_out` = 8'h41, and `level_out` returns to 0.
2. **Fill and backpressure:** with `DEPTH` = 4 and `busy_in` held high, push 6 bytes 8'h30–8'h35 → `char_in_ready` falls after 4 accepted, `level_out` = 4. Release busy → output order is 30, 31, 32, 33, then 34, 35 once re-accepted.
3. **Simultaneous push/pop:** at level 2, push during the pop cycle → `level_out` stays 2 and no byte is lost or duplicated.
4. **Guard window:** busy model asserts 2 cycles after trigger → no second trigger before busy falls, and exactly one trigger per byte.
5. **CRLF:** with `UART_TX_BUF_CRLF_EN` defined, push "ok\n" → transmitted 6F, 6B, 0D, 0A. Without the macro → 6F, 6B, 0A.
6. **Reset mid-drain:** assert `rst_in` in `DRAIN` with level 3 → next cycle `level_out` = 0, `trigger_out` = 0, FSM `IDLE`, and no trigger until new data arrives and `busy_in` is low.

Source files
------------

// File: rtl/uart_tx_buffer_pkg.sv
// Shared types and constants for the FPGA-to-host UART transmit path.
package uart_tx_buffer_pkg;

    localparam int UART_TX_BUF_DEPTH_DEFAULT = 64;
    localparam int UART_TX_BUF_GUARD_DEFAULT = 2;

    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_CR = 8'h0D;

    typedef enum logic [1:0] {
        IDLE,
        GUARD_WAIT,
        DRAIN
    } tx_buf_state_t;

endpackage

// File: rtl/uart_tx_buffer_fifo.sv
// sync_fifo: single-clock FIFO with level/full/empty and a show-ahead head output.
module sync_fifo
    import uart_tx_buffer_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = UART_TX_BUF_DEPTH_DEFAULT
) (
    input  logic                     clk_in,
    input  logic                     rst_in,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         head,
    output logic [$clog2(DEPTH):0]   level,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [LW-1:0]    count;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == LW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr];
    assign level   = count;

    // NOTE: storage has no reset; the pointers and count define which entries are valid.
    always_ff @(posedge clk_in) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointers are AW bits wide, so DEPTH being a power of two makes wrap implicit.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_buffer.sv
// Elastic byte buffer feeding uart_transmit via trigger/busy.
// Optional CR insertion before each LF when UART_TX_BUF_CRLF_EN is defined.
module uart_tx_buffer
    import uart_tx_buffer_pkg::*;
#(
    parameter int DEPTH = UART_TX_BUF_DEPTH_DEFAULT,
    parameter int GUARD = UART_TX_BUF_GUARD_DEFAULT
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic [7:0]             char_in,
    input  logic                   char_in_valid,
    output logic                   char_in_ready,
    output logic [7:0]             data_byte_out,
    output logic                   trigger_out,
    input  logic                   busy_in,
    output logic [$clog2(DEPTH):0] level_out
);

    localparam int GCW = $clog2(GUARD + 1) + 1;

    tx_buf_state_t  state;
    logic [GCW-1:0] guard_cnt;
    logic           guard_done;

    logic [7:0]     fifo_head;
    logic           fifo_full;
    logic           fifo_empty;
    logic           fifo_pop;

    logic           launch;
    logic           insert_cr;
    logic [7:0]     launch_byte;

    sync_fifo #(
        .WIDTH (8),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk_in    (clk_in),
        .rst_in    (rst_in),
        .push      (char_in_valid),
        .push_data (char_in),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .level     (level_out),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Ready comes from the registered count alone; a same-cycle pop does not free a slot.
    assign char_in_ready = !fifo_full;

    assign guard_done = (int'(guard_cnt) + 1 >= GUARD);

`ifdef UART_TX_BUF_CRLF_EN
    logic pending_lf;

    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            pending_lf <= 1'b0;
        end else if (launch) begin
            pending_lf <= insert_cr;
        end
    end
`endif

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        launch    = (state == IDLE) && !fifo_empty && !busy_in;
        insert_cr = 1'b0;
`ifdef UART_TX_BUF_CRLF_EN
        insert_cr = launch && (fifo_head == ASCII_LF) && !pending_lf;
`endif
        fifo_pop    = launch && !insert_cr;
        launch_byte = insert_cr ? ASCII_CR : fifo_head;
    end

    // busy_in is ignored during GUARD_WAIT to cover the transmitter's busy-assert latency.
    always_ff @(posedge clk_in) begin
        if (rst_in) begin
            state         <= IDLE;
            data_byte_out <= 8'h00;
            trigger_out   <= 1'b0;
            guard_cnt     <= '0;
        end else begin
            trigger_out <= 1'b0;
            case (state)
                IDLE: begin
                    if (launch) begin
                        data_byte_out <= launch_byte;
                        trigger_out   <= 1'b1;
                        guard_cnt     <= '0;
                        state         <= GUARD_WAIT;
                    end
                end
                GUARD_WAIT: begin
                    if (guard_done) begin
                        state <= DRAIN;
                    end else begin
                        guard_cnt <= guard_cnt + 1'b1;
                    end
                end
                DRAIN: begin
                    if (!busy_in) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
